// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 physical-side bus controller.
// Executes 12-bit {code, arg} words from the command sequencer and owns all
// LCD bus timing: power-up wait, init sequence, enable pulses and execution
// delays. It paces the sequencer with a 2-cycle rdy strobe per fetch.
// Optional feature macro: LCD_BUS_INIT_EN. When it is defined, the power-up
// wait and the 7-byte init sequence are built in. When it is undefined, the
// block starts fetching right after reset.
module lcd_bus_driver #(
  parameter int POWERUP_CYC = 750000,
  parameter int E_CYC       = 12,
  parameter int CMD_CYC     = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int SETTLE_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cmd,
  output logic        rdy,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        init_done
);

  localparam int MAX_1   = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int MAX_2   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
  localparam int MAX_3   = (MAX_2 > SETTLE_CYC) ? MAX_2 : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_1 > MAX_3) ? MAX_1 : MAX_3;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Down-counter reload values: a state lasting N cycles is entered with N-1.
  localparam logic [CNT_W-1:0] FETCH_LD  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD      = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LEN   = CNT_W'(CMD_CYC);
  localparam logic [CNT_W-1:0] CLEAR_LEN = CNT_W'(CLEAR_CYC);

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT, S_FETCH, S_SETTLE, S_DECODE,
    S_SETUP, S_EHIGH, S_HOLD, S_DELAY
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [11:0]      cmd_q, cmd_d;
  logic             rdy_q, rdy_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             init_done_q, init_done_d;
`ifdef LCD_BUS_INIT_EN
  logic [2:0]       init_idx_q, init_idx_d;
  logic [7:0]       init_byte;
  logic [CNT_W-1:0] init_len;
`endif

  // Decoded view of the latched command word.
  logic [3:0]       code;
  logic [7:0]       arg;
  logic             dec_bus;
  logic             dec_skip;
  logic             dec_rs;
  logic [7:0]       dec_data;
  logic [CNT_W-1:0] dec_len;

  assign code = cmd_q[11:8];
  assign arg  = cmd_q[7:0];

  // Translate the sequencer command into a bus byte, RS and execution delay.
  always_comb begin
    dec_bus  = 1'b0;
    dec_skip = 1'b0;
    dec_rs   = 1'b0;
    dec_data = 8'h00;
    dec_len  = CMD_LEN;
    case (code)
      4'd0: begin
        dec_bus  = 1'b1;
        dec_data = 8'h01;
        dec_len  = CLEAR_LEN;
      end
      4'd1: begin
        dec_bus  = 1'b1;
        dec_rs   = 1'b1;
        dec_data = arg;
      end
      4'd2: begin
        dec_bus  = 1'b1;
        dec_data = {2'b01, arg[5:0]};
      end
      4'd3: begin
        // Linear position 0..79 maps onto DDRAM rows at 0x00 and 0x40.
        if (arg < 8'd40) begin
          dec_bus  = 1'b1;
          dec_data = 8'h80 | arg;
        end else if (arg < 8'd80) begin
          dec_bus  = 1'b1;
          dec_data = 8'h80 | (arg + 8'd24);
        end else begin
          dec_skip = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef LCD_BUS_INIT_EN
  // Fixed 8-bit-mode init bytes; the first wake-up and the clear need the long delay.
  always_comb begin
    init_byte = 8'h30;
    init_len  = CMD_LEN;
    case (init_idx_q)
      3'd0: begin init_byte = 8'h30; init_len = CLEAR_LEN; end
      3'd1: init_byte = 8'h30;
      3'd2: init_byte = 8'h30;
      3'd3: init_byte = 8'h38;
      3'd4: init_byte = 8'h0C;
      3'd5: init_byte = 8'h06;
      3'd6: begin init_byte = 8'h01; init_len = CLEAR_LEN; end
      default: ;
    endcase
  end
`endif

  // Next-state logic: sequencing, counter reloads and bus value selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    cmd_d       = cmd_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    init_done_d = init_done_q;
`ifdef LCD_BUS_INIT_EN
    init_idx_d  = init_idx_q;
`else
    init_done_d = 1'b1;
`endif
    case (state_q)
      S_PWRUP: begin
`ifdef LCD_BUS_INIT_EN
        // Counter leaves reset at zero, so the power-up wait counts upward.
        if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = S_FETCH;
        cnt_d   = FETCH_LD;
`endif
      end
`ifdef LCD_BUS_INIT_EN
      S_INIT: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_byte;
        dly_d      = init_len;
        state_d    = S_SETUP;
        cnt_d      = E_LD;
      end
`endif
      S_FETCH: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cmd_d   = cmd;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_bus) begin
          lcd_rs_d   = dec_rs;
          lcd_data_d = dec_data;
          dly_d      = dec_len;
          state_d    = S_SETUP;
          cnt_d      = E_LD;
        end else if (dec_skip) begin
          state_d = S_FETCH;
          cnt_d   = FETCH_LD;
        end else begin
          dly_d   = dec_len;
          state_d = S_DELAY;
          cnt_d   = dec_len - CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EHIGH;
          cnt_d   = E_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EHIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = E_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DELAY;
          cnt_d   = dly_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_FETCH;
          cnt_d   = FETCH_LD;
`ifdef LCD_BUS_INIT_EN
          if (!init_done_q) begin
            if (init_idx_q == 3'd6) begin
              init_done_d = 1'b1;
            end else begin
              init_idx_d = init_idx_q + 3'd1;
              state_d    = S_INIT;
              cnt_d      = '0;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
    // Strobes follow the next state so they are registered and aligned with it.
    rdy_d   = (state_d == S_FETCH);
    lcd_e_d = (state_d == S_EHIGH);
  end

  // Control and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      dly_q       <= '0;
      rdy_q       <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      init_done_q <= 1'b0;
`ifdef LCD_BUS_INIT_EN
      init_idx_q  <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      rdy_q       <= rdy_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      init_done_q <= init_done_d;
`ifdef LCD_BUS_INIT_EN
      init_idx_q  <= init_idx_d;
`endif
    end
  end

  // Command word latch; only meaningful once SETTLE has sampled it.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  assign rdy       = rdy_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = lcd_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed plus randomized bench for lcd_bus_driver using
// the reduced test-plan timing parameters and a command-level reference model.
module tb_lcd_bus_driver;

  localparam int PWR = 100;
  localparam int E   = 2;
  localparam int CMD = 20;
  localparam int CLR = 200;
  localparam int SET = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cmd;
  logic        rdy;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        init_done;

  int n_pass  = 0;
  int n_total = 0;

  lcd_bus_driver #(
    .POWERUP_CYC(PWR),
    .E_CYC      (E),
    .CMD_CYC    (CMD),
    .CLEAR_CYC  (CLR),
    .SETTLE_CYC (SET)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .rdy      (rdy),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the LCD should see for one sequencer command.
  task automatic model(input logic [11:0] c, output bit bus, output logic rs,
                       output logic [7:0] d, output int delay);
    int code;
    int arg;
    code  = int'(c[11:8]);
    arg   = int'(c[7:0]);
    bus   = 1'b0;
    rs    = 1'b0;
    d     = 8'h00;
    delay = CMD;
    case (code)
      0: begin bus = 1'b1; d = 8'h01; delay = CLR; end
      1: begin bus = 1'b1; rs = 1'b1; d = c[7:0]; end
      2: begin bus = 1'b1; d = 8'(64 + arg % 64); end
      3: begin
        if (arg >= 80) begin
          delay = 0;
        end else begin
          bus = 1'b1;
          d   = 8'(128 + (arg / 40) * 64 + arg % 40);
        end
      end
      default: ;
    endcase
  endtask

  // Called at the sample point where rdy has just risen; runs until the next rise.
  task automatic run_cmd(input logic [11:0] c);
    bit         bus;
    logic       rs_e;
    logic [7:0] d_e;
    int         delay;
    int         cyc, rdy_hi, pulses, e_w, unstable, rw_bad;
    logic       prev_rdy, prev_e, rs_s;
    logic [7:0] d_s;
    bit         done;
    model(c, bus, rs_e, d_e, delay);
    cmd      = c;
    cyc      = 0;
    rdy_hi   = 1;
    pulses   = 0;
    e_w      = 0;
    unstable = 0;
    rw_bad   = 0;
    prev_rdy = 1'b1;
    prev_e   = 1'b0;
    rs_s     = 1'b0;
    d_s      = 8'h00;
    done     = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (rdy && !prev_rdy) begin
        done = 1'b1;
      end else begin
        if (rdy) rdy_hi++;
        if (lcd_rw !== 1'b0) rw_bad++;
        if (lcd_e && !prev_e) begin
          pulses++;
          rs_s = lcd_rs;
          d_s  = lcd_data;
        end
        if (lcd_e) begin
          e_w++;
          if (lcd_rs !== rs_s || lcd_data !== d_s) unstable++;
        end
      end
      prev_rdy = rdy;
      prev_e   = lcd_e;
    end
    chk($sformatf("interval cmd=%03h", c), cyc, 2 + SET + 1 + (bus ? 3 * E : 0) + delay);
    chk($sformatf("rdy_width cmd=%03h", c), rdy_hi, 2);
    chk($sformatf("e_pulses cmd=%03h", c), pulses, bus ? 1 : 0);
    chk($sformatf("rw_low cmd=%03h", c), rw_bad, 0);
    if (bus) begin
      chk($sformatf("rs cmd=%03h", c), rs_s, rs_e);
      chk($sformatf("data cmd=%03h", c), d_s, d_e);
      chk($sformatf("e_width cmd=%03h", c), e_w, E);
      chk($sformatf("stable cmd=%03h", c), unstable, 0);
    end
  endtask

  // After reset release: wait for the first rdy rise and check what precedes it.
  task automatic after_release();
    int         t;
    int         t_first_e;
    int         rs_hi;
    logic       prev_e;
    logic [7:0] seen[$];
`ifdef LCD_BUS_INIT_EN
    logic [7:0] exp_init[7];
    exp_init = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h06, 8'h01};
`endif
    t         = 0;
    t_first_e = -1;
    rs_hi     = 0;
    prev_e    = 1'b0;
    seen      = {};
    cmd       = 12'hF00;
    rst_n     = 1'b1;
    do begin
      @(negedge clk);
      t++;
      if (lcd_e && !prev_e) begin
        seen.push_back(lcd_data);
        if (lcd_rs) rs_hi++;
        if (t_first_e < 0) t_first_e = t;
      end
      prev_e = lcd_e;
`ifndef LCD_BUS_INIT_EN
      if (t == 1) chk("init_done_first_cycle", init_done, 1'b1);
`endif
    end while (!rdy && t < 5000);
    chk("first_rdy_seen", rdy, 1'b1);
    chk("init_done_at_rdy", init_done, 1'b1);
    chk("init_rs_low", rs_hi, 0);
`ifdef LCD_BUS_INIT_EN
    chk("first_e_window", (t_first_e >= PWR + E - 1) && (t_first_e <= PWR + E + 2), 1'b1);
    chk("init_count", seen.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("init_byte%0d", i), (i < seen.size()) ? seen[i] : 8'hXX, exp_init[i]);
    end
`else
    chk("first_rdy_le2", t <= 2, 1'b1);
    chk("no_init_bytes", seen.size(), 0);
`endif
  endtask

  initial begin
    logic [11:0] directed[12];
    logic [11:0] c;
    int          t;
    directed = '{12'h141, 12'h308, 12'h328, 12'h330, 12'h35A, 12'h000,
                 12'h327, 12'h34F, 12'h2FF, 12'h400, 12'hF00, 12'h1A5};

    // Reset state
    rst_n = 1'b0;
    cmd   = 12'hF00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_e", lcd_e, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_init_done", init_done, 1'b0);

    after_release();

    // Directed commands, including setad row boundaries and the out-of-range skip
    for (int i = 0; i < 12; i++) run_cmd(directed[i]);

    // Randomized commands; setad arguments biased toward the row boundaries
    for (int i = 0; i < 40; i++) begin
      c[11:8] = 4'($urandom_range(0, 15));
      c[7:0]  = 8'($urandom_range(0, 255));
      if (c[11:8] == 4'd3) c[7:0] = 8'($urandom_range(30, 90));
      run_cmd(c);
    end

    // Reset in the middle of an enable pulse
    cmd = 12'h155;
    t   = 0;
    while (!lcd_e && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reached_ehigh", lcd_e, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_e", lcd_e, 1'b0);
    chk("midrst_rdy", rdy, 1'b0);
    chk("midrst_data", lcd_data, 8'h00);
    chk("midrst_init_done", init_done, 1'b0);
    @(negedge clk);

    after_release();
    run_cmd(12'h141);
    run_cmd(12'h35A);
    run_cmd(12'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Physical-side controller for the 16x2 HD44780 character LCD. It executes the 12-bit command words produced by the LCD command sequencer and owns all bus timing: power-up wait, init sequence, enable pulses and per-command execution delays. It paces the sequencer with an `rdy` strobe: one strobe per command fetched. It sits between the sequencer and the LCD pins at top level.

## Interface
Parameters (defaults for 50 MHz):
- `POWERUP_CYC`, 750000: wait after reset before first LCD access (15 ms)
- `E_CYC`, 12: length of each of the setup, `lcd_e`-high and hold phases (240 ns)
- `CMD_CYC`, 2000: execution delay after a normal instruction (40 us)
- `CLEAR_CYC`, 82000: execution delay after clear (1.64 ms)
- `SETTLE_CYC`, 4: cycles from `rdy` falling to `cmd` sampling

Ports:
- `clk` in 1: system clock; all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `cmd` in 12: `{code[11:8], arg[7:0]}` from the sequencer
- `rdy` out 1: fetch strobe; sequencer advances on its rising edge
- `lcd_e` out 1: LCD enable
- `lcd_rs` out 1: register select (1 = data)
- `lcd_rw` out 1: always 0 (write-only)
- `lcd_data` out 8: LCD data bus
- `init_done` out 1: high once the init sequence is complete

## Operation
- Reset values: `rdy`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `init_done`=0, state=PWRUP.
- States: PWRUP → INIT → FETCH → SETTLE → DECODE → SETUP → EHIGH → HOLD → DELAY → FETCH.
- PWRUP: count `POWERUP_CYC` cycles. Then go to INIT.
- INIT: issue, in order, 0x30, 0x30, 0x30, 0x38 (function set), 0x0C (display on), 0x06 (entry mode), 0x01 (clear). All use RS=0 and the same SETUP/EHIGH/HOLD/DELAY path. Delays:
  - first 0x30: `CLEAR_CYC`
  - 0x01: `CLEAR_CYC`
  - all others: `CMD_CYC`
- After the last INIT delay, `init_done`=1 and the state goes to FETCH. `init_done` stays 1 until reset.
- FETCH: `rdy`=1 for exactly 2 cycles, then 0. Then go to SETTLE.
- SETTLE: wait `SETTLE_CYC` cycles, then register `cmd`. Only this registered copy is used afterwards.
- DECODE, by `code`:
  - 0 clear: RS=0, data 0x01, delay `CLEAR_CYC`
  - 1 write: RS=1, data=`arg`, delay `CMD_CYC`
  - 2 setcg: RS=0, data=0x40|`arg[5:0]`, delay `CMD_CYC`
  - 3 setad: RS=0, data=0x80|addr, delay `CMD_CYC`
    - `arg`<40: addr=`arg` (row 0)
    - 40≤`arg`<80: addr=`arg`+24 (row 1, 0x40..0x67)
    - `arg`≥80: no bus cycle; go straight to FETCH
  - 4 wait2: no bus cycle; DELAY for `CMD_CYC`
  - 15 wait1, and codes 5..14: no bus cycle; DELAY for `CMD_CYC`, then FETCH. This is the idle poll.
- SETUP: drive `lcd_rs`/`lcd_data` with `lcd_e`=0 for `E_CYC` cycles.
- EHIGH: `lcd_e`=1 for `E_CYC` cycles.
- HOLD: `lcd_e`=0; `lcd_rs`/`lcd_data` stay unchanged for `E_CYC` cycles.
- DELAY: count the selected delay. `lcd_data`/`lcd_rs` keep their last values.
- Only one command is in flight at a time. `rdy` never pulses while a command is executing.

## Timing
- Cycles from `rst_n` release to the first `lcd_e` rise: `POWERUP_CYC` + `E_CYC` (±1).
- Per bus command, cycles from the `rdy` rise to the next `rdy` rise: 2 + `SETTLE_CYC` + 1 + 3·`E_CYC` + delay.
- For a no-bus code, the same interval omits the 3·`E_CYC` term.
- `lcd_e` is glitch-free and registered. `lcd_rs`/`lcd_data` never change while `lcd_e`=1.
- Reset mid-operation: on the first rising edge with `rst_n`=0, every output takes its reset value, including `lcd_e`=0 even mid-pulse. All counters clear. The block restarts from PWRUP.
- Counters are wide enough for the largest parameter. Each down-counter reload happens in the cycle the state is entered.

## Configuration
- `LCD_BUS_INIT_EN`:
  - Defined: PWRUP and INIT behave as above.
  - Undefined: PWRUP and INIT are compiled out. After reset the block enters FETCH directly, with `init_done`=1 from the first cycle after reset. Use this for simulation and for boards where the sequencer issues init itself.

## Test plan
Bench parameters: `POWERUP_CYC`=100, `E_CYC`=2, `CMD_CYC`=20, `CLEAR_CYC`=200, `SETTLE_CYC`=2.
- Reset, then hold `cmd`=0xF00 → 7 INIT enables on `lcd_data` 30,30,30,38,0C,06,01 with RS=0. Then `init_done`=1, then the first `rdy` pulse, 2 cycles wide.
- `cmd`=0x141 after a `rdy` → one `lcd_e` pulse, 2 cycles, with RS=1 and data 0x41. Next `rdy` rise is exactly 2+2+1+6+20 = 31 cycles after the previous rise.
- setad `arg`=8, then 40, then 48, then 90 → data 0x88, 0xC0, 0xC8; `arg`=90 gives no `lcd_e` pulse, and the next `rdy` comes 5 cycles after that command's `rdy` rise.
- `cmd`=0x000 → data 0x01, RS=0; the next `rdy` rise comes 211 cycles after the current one.
- Assert `rst_n`=0 during EHIGH → `lcd_e`=0 and `rdy`=0 at the next edge; after release, the first `lcd_e` rise comes ~102 cycles later.
- Build without `LCD_BUS_INIT_EN` → first `rdy` rise within 2 cycles of reset release, and no INIT bytes on the bus.
